// File: rtl/hyperram_burst_scheduler.sv
// hyperram_burst_scheduler
//
// Client-side front end for the HyperRAM controller. It takes one long read
// or write job and cuts it into controller bursts of at most MAX_BURST bytes.
// For each write burst it loads the controller write FIFO first, then queues
// the command. For each read burst it queues the command first, waits for the
// transfer to finish, and then drains the read FIFO into a push-only stream.
//
// Ports
//   clk_50, resetn           : sole clock, asynchronous active-low reset
//   job_start/addr/len/rw    : job request (addr in 16-bit words, len in bytes)
//   job_busy/done/error      : job status (error is a sticky timeout flag)
//   wr_data/valid/ready      : application write byte stream
//   rd_data/valid            : application read byte stream, no backpressure
//   ctl_adr/len/rw/strobe    : controller queue command
//   ctl_busy                 : controller transfer status
//   ctl_wdata/wreq           : controller write FIFO push
//   ctl_rreq/rdata           : controller read FIFO pop, data one cycle later

module hyperram_burst_scheduler #(
  parameter int MAX_BURST = 1280,
  parameter int LEN_W     = 20,
  parameter int TIMEOUT   = 4096
) (
  input  logic             clk_50,
  input  logic             resetn,
  input  logic             job_start,
  input  logic [22:0]      job_addr,
  input  logic [LEN_W-1:0] job_len,
  input  logic             job_rw,
  output logic             job_busy,
  output logic             job_done,
  output logic             job_error,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [22:0]      ctl_adr,
  output logic [10:0]      ctl_len,
  output logic             ctl_rw,
  output logic             ctl_strobe,
  input  logic             ctl_busy,
  output logic [7:0]       ctl_wdata,
  output logic             ctl_wreq,
  output logic             ctl_rreq,
  input  logic [7:0]       ctl_rdata
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BURST);
  localparam logic [10:0]      MAX_BLEN = 11'(MAX_BURST);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    SETUP,
    LOAD,
    CMD,
    WAIT_START,
    WAIT_END,
    DRAIN,
    NEXT,
    DONE
  } stateT;

  stateT            state;
  logic [22:0]      addr;
  logic [LEN_W-1:0] remain;
  logic             rwLatched;
  logic [10:0]      blen;
  logic [10:0]      cnt;
  logic [TMO_W-1:0] tmo;
  logic             rreqQ;

  // Job sequencer. All outputs except the read stream are registered here.
  // job_busy stays high through the job_done cycle so that a start arriving
  // together with job_done is ignored.
  always_ff @(posedge clk_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      addr       <= '0;
      remain     <= '0;
      rwLatched  <= 1'b0;
      blen       <= '0;
      cnt        <= '0;
      tmo        <= '0;
      job_busy   <= 1'b0;
      job_done   <= 1'b0;
      job_error  <= 1'b0;
      wr_ready   <= 1'b0;
      ctl_adr    <= '0;
      ctl_len    <= '0;
      ctl_rw     <= 1'b0;
      ctl_strobe <= 1'b0;
      ctl_wdata  <= '0;
      ctl_wreq   <= 1'b0;
      ctl_rreq   <= 1'b0;
    end else begin
      ctl_strobe <= 1'b0;
      ctl_wreq   <= 1'b0;
      job_done   <= 1'b0;
      case (state)
        IDLE: begin
          job_busy <= 1'b0;
          if (job_start && !job_busy) begin
            addr      <= job_addr;
            remain    <= {job_len[LEN_W-1:1], 1'b0};
            rwLatched <= job_rw;
            job_error <= 1'b0;
            job_busy  <= 1'b1;
            state     <= (job_len[LEN_W-1:1] == '0) ? DONE : SETUP;
          end
        end

        SETUP: begin
          blen <= (remain > MAX_LEN) ? MAX_BLEN : remain[10:0];
          cnt  <= '0;
          if (rwLatched) begin
            state <= CMD;
          end else begin
            // A burst is never empty here, so the first byte is always wanted.
            wr_ready <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          if (wr_valid && wr_ready) begin
            ctl_wreq  <= 1'b1;
            ctl_wdata <= wr_data;
            cnt       <= cnt + 11'd1;
            if (cnt + 11'd1 == blen) begin
              wr_ready <= 1'b0;
            end
          end
          if (cnt == blen) begin
            state <= CMD;
          end
        end

        CMD: begin
          ctl_strobe <= 1'b1;
          ctl_adr    <= addr;
          ctl_len    <= blen;
          ctl_rw     <= rwLatched;
          tmo        <= '0;
          state      <= WAIT_START;
        end

        WAIT_START: begin
          if (ctl_busy) begin
            tmo   <= '0;
            state <= WAIT_END;
          end else if (tmo == TMO_LAST) begin
            job_error <= 1'b1;
            state     <= DONE;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end

        WAIT_END: begin
          if (!ctl_busy) begin
            if (rwLatched) begin
              cnt      <= '0;
              ctl_rreq <= 1'b1;
              state    <= DRAIN;
            end else begin
              state <= NEXT;
            end
          end else if (tmo == TMO_LAST) begin
            job_error <= 1'b1;
            state     <= DONE;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end

        // ctl_rreq was raised on entry, so it is high for exactly blen cycles.
        DRAIN: begin
          cnt <= cnt + 11'd1;
          if (cnt + 11'd1 == blen) begin
            ctl_rreq <= 1'b0;
            state    <= NEXT;
          end
        end

        NEXT: begin
          addr   <= addr + 23'(blen[10:1]);
          remain <= remain - LEN_W'(blen);
          state  <= (remain == LEN_W'(blen)) ? DONE : SETUP;
        end

        DONE: begin
          job_done <= 1'b1;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Read return path: FIFO data arrives the cycle after ctl_rreq and is
  // re-registered once more before it reaches the application.
  always_ff @(posedge clk_50 or negedge resetn) begin
    if (!resetn) begin
      rreqQ    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rreqQ    <= ctl_rreq;
      rd_valid <= rreqQ;
      if (rreqQ) begin
        rd_data <= ctl_rdata;
      end
    end
  end

endmodule

// File: tb/tb_hyperram_burst_scheduler.sv
// tb_hyperram_burst_scheduler
//
// Directed bench for hyperram_burst_scheduler. A small controller model
// raises ctl_busy 5 cycles after each strobe for 10 cycles and serves the
// read FIFO from a preloaded table. A monitor on the falling edge logs
// strobes, FIFO traffic, read stream and job completions.

module tb_hyperram_burst_scheduler;

  logic        clk_50 = 1'b0;
  logic        resetn;
  logic        job_start;
  logic [22:0] job_addr;
  logic [19:0] job_len;
  logic        job_rw;
  logic        job_busy;
  logic        job_done;
  logic        job_error;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [22:0] ctl_adr;
  logic [10:0] ctl_len;
  logic        ctl_rw;
  logic        ctl_strobe;
  logic        ctl_busy;
  logic [7:0]  ctl_wdata;
  logic        ctl_wreq;
  logic        ctl_rreq;
  logic [7:0]  ctl_rdata;

  int checks = 0;
  int passed = 0;

  hyperram_burst_scheduler #(
    .MAX_BURST(1280),
    .LEN_W(20),
    .TIMEOUT(16)
  ) dut (
    .clk_50(clk_50),
    .resetn(resetn),
    .job_start(job_start),
    .job_addr(job_addr),
    .job_len(job_len),
    .job_rw(job_rw),
    .job_busy(job_busy),
    .job_done(job_done),
    .job_error(job_error),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .ctl_adr(ctl_adr),
    .ctl_len(ctl_len),
    .ctl_rw(ctl_rw),
    .ctl_strobe(ctl_strobe),
    .ctl_busy(ctl_busy),
    .ctl_wdata(ctl_wdata),
    .ctl_wreq(ctl_wreq),
    .ctl_rreq(ctl_rreq),
    .ctl_rdata(ctl_rdata)
  );

  always #10 clk_50 = ~clk_50;

  // Controller and write-source model
  int         pend;
  int         busyLeft;
  logic       busyEn = 1'b1;
  int         wrMode = 0;
  logic [7:0] rdFifo [16];
  logic [3:0] rdPtr;
  logic [7:0] wrByte;

  assign wr_data = wrByte;

  always @(posedge clk_50 or negedge resetn) begin
    if (!resetn) begin
      ctl_busy  <= 1'b0;
      pend      <= 0;
      busyLeft  <= 0;
      ctl_rdata <= 8'h00;
      rdPtr     <= 4'd0;
      wrByte    <= 8'h00;
      wr_valid  <= 1'b0;
    end else begin
      if (ctl_strobe && busyEn) begin
        pend <= 5;
      end else if (pend > 0) begin
        pend <= pend - 1;
        if (pend == 1) begin
          ctl_busy <= 1'b1;
          busyLeft <= 10;
        end
      end
      if (ctl_busy) begin
        busyLeft <= busyLeft - 1;
        if (busyLeft == 1) ctl_busy <= 1'b0;
      end
      if (ctl_rreq) begin
        ctl_rdata <= rdFifo[rdPtr];
        rdPtr     <= rdPtr + 4'd1;
      end
      if (wr_valid && wr_ready) wrByte <= wrByte + 8'd1;
      case (wrMode)
        1:       wr_valid <= 1'b1;
        2:       wr_valid <= ~wr_valid;
        default: wr_valid <= 1'b0;
      endcase
    end
  end

  // Monitor
  int          cycleCount = 0;
  int          strobeCount = 0;
  logic [22:0] strAdr [64];
  logic [10:0] strLen [64];
  logic        strRw [64];
  int          strCycle [64];
  int          strWreq [64];
  int          wreqCount = 0;
  int          lastWreqCycle = 0;
  logic [7:0]  expWByte = 8'h00;
  int          wdataErr = 0;
  int          rreqCount = 0;
  int          firstRreqCycle = 0;
  int          lastRreqCycle = 0;
  int          rdCount = 0;
  int          firstRdCycle = 0;
  int          lastRdCycle = 0;
  logic [7:0]  rdLog [16];
  int          busyFallCycle = 0;
  int          doneCount = 0;
  int          doneCycle = 0;
  logic        prevRreq = 1'b0;
  logic        prevRdValid = 1'b0;
  logic        prevBusy = 1'b0;

  always @(negedge clk_50) begin
    cycleCount = cycleCount + 1;
    if (ctl_wreq) begin
      if (ctl_wdata !== expWByte) wdataErr = wdataErr + 1;
      expWByte      = expWByte + 8'd1;
      wreqCount     = wreqCount + 1;
      lastWreqCycle = cycleCount;
    end
    if (ctl_strobe) begin
      if (strobeCount < 64) begin
        strAdr[strobeCount]   = ctl_adr;
        strLen[strobeCount]   = ctl_len;
        strRw[strobeCount]    = ctl_rw;
        strCycle[strobeCount] = cycleCount;
        strWreq[strobeCount]  = wreqCount;
      end
      strobeCount = strobeCount + 1;
    end
    if (ctl_rreq) begin
      if (!prevRreq) firstRreqCycle = cycleCount;
      lastRreqCycle = cycleCount;
      rreqCount     = rreqCount + 1;
    end
    if (rd_valid) begin
      if (!prevRdValid) firstRdCycle = cycleCount;
      lastRdCycle = cycleCount;
      if (rdCount < 16) rdLog[rdCount] = rd_data;
      rdCount = rdCount + 1;
    end
    if (prevBusy && !ctl_busy) busyFallCycle = cycleCount;
    if (job_done) begin
      doneCount = doneCount + 1;
      doneCycle = cycleCount;
    end
    prevRreq    = ctl_rreq;
    prevRdValid = rd_valid;
    prevBusy    = ctl_busy;
    if (!resetn) expWByte = 8'h00;
  end

  // Issue one job and wait (bounded) for job_done
  task automatic runJob(input logic [22:0] a, input logic [19:0] l, input logic rw,
                        input int limit, output bit seen);
    @(negedge clk_50);
    job_start = 1'b1;
    job_addr  = a;
    job_len   = l;
    job_rw    = rw;
    @(negedge clk_50);
    job_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (k > 0) @(negedge clk_50);
      #1;
      if (job_done) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk_50);
    #1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    job_start = 1'b0;
    job_addr  = '0;
    job_len   = '0;
    job_rw    = 1'b0;
    wrMode    = 0;
    busyEn    = 1'b1;
    for (int i = 0; i < 16; i++) rdFifo[i] = 8'h11 + 8'(i);
    repeat (3) @(negedge clk_50);
    #1;
    checks++;
    if ({job_busy, job_done, job_error, wr_ready, rd_data, rd_valid, ctl_adr, ctl_len,
         ctl_rw, ctl_strobe, ctl_wdata, ctl_wreq, ctl_rreq} !== 59'd0)
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b err=%b rdy=%b strobe=%b expected all 0",
               job_busy, job_done, job_error, wr_ready, ctl_strobe);
    else passed++;
    @(negedge clk_50);
    resetn = 1'b1;
    repeat (2) @(negedge clk_50);
    #1;
    checks++;
    if ({job_busy, job_done, wr_ready, ctl_strobe} !== 4'b0000)
      $display("[TB] FAIL idle_after_reset: got %b expected 0000",
               {job_busy, job_done, wr_ready, ctl_strobe});
    else passed++;
  endtask

  task automatic test_zero_length();
    int baseS;
    int baseD;
    baseS = strobeCount;
    baseD = doneCount;
    @(negedge clk_50);
    job_start = 1'b1;
    job_addr  = 23'h000123;
    job_len   = 20'd0;
    job_rw    = 1'b0;
    @(negedge clk_50);
    job_start = 1'b0;
    #1;
    checks++;
    if (job_busy !== 1'b1) $display("[TB] FAIL zero_busy: got %b expected 1", job_busy);
    else passed++;
    @(negedge clk_50);
    #1;
    checks++;
    if (job_done !== 1'b1) $display("[TB] FAIL zero_done_latency: got %b expected 1", job_done);
    else passed++;
    // start in the job_done cycle must be ignored
    job_start = 1'b1;
    job_len   = 20'd4;
    @(negedge clk_50);
    job_start = 1'b0;
    #1;
    checks++;
    if (job_busy !== 1'b0) $display("[TB] FAIL start_with_done_ignored: got busy %b expected 0", job_busy);
    else passed++;
    repeat (4) @(negedge clk_50);
    #1;
    checks++;
    if (strobeCount - baseS !== 0) $display("[TB] FAIL zero_no_strobe: got %0d expected 0", strobeCount - baseS);
    else passed++;
    checks++;
    if (doneCount - baseD !== 1) $display("[TB] FAIL zero_done_count: got %0d expected 1", doneCount - baseD);
    else passed++;
  endtask

  task automatic test_write_split();
    int baseS;
    int baseW;
    int baseD;
    bit seen;
    logic [22:0] expAdr [3];
    logic [10:0] expLen [3];
    int expWr [3];
    expAdr[0] = 23'h000100; expAdr[1] = 23'h000380; expAdr[2] = 23'h000600;
    expLen[0] = 11'd1280;   expLen[1] = 11'd1280;   expLen[2] = 11'd440;
    expWr[0]  = 1280;       expWr[1]  = 2560;       expWr[2]  = 3000;
    baseS = strobeCount;
    baseW = wreqCount;
    baseD = doneCount;
    wrMode = 1;
    runJob(23'h000100, 20'd3000, 1'b0, 6000, seen);
    wrMode = 0;
    checks++;
    if (seen !== 1'b1) $display("[TB] FAIL write_done_timeout: got %b expected 1", seen);
    else passed++;
    checks++;
    if (strobeCount - baseS !== 3) $display("[TB] FAIL write_strobe_count: got %0d expected 3", strobeCount - baseS);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({strAdr[baseS+i], strLen[baseS+i], strRw[baseS+i]} !== {expAdr[i], expLen[i], 1'b0})
        $display("[TB] FAIL write_burst%0d: got adr %h len %0d rw %b expected adr %h len %0d rw 0",
                 i, strAdr[baseS+i], strLen[baseS+i], strRw[baseS+i], expAdr[i], expLen[i]);
      else passed++;
      checks++;
      if (strWreq[baseS+i] - baseW !== expWr[i])
        $display("[TB] FAIL write_bytes_before_strobe%0d: got %0d expected %0d",
                 i, strWreq[baseS+i] - baseW, expWr[i]);
      else passed++;
    end
    checks++;
    if (wreqCount - baseW !== 3000) $display("[TB] FAIL write_wreq_total: got %0d expected 3000", wreqCount - baseW);
    else passed++;
    checks++;
    if (wdataErr !== 0) $display("[TB] FAIL write_data_order: got %0d bad bytes expected 0", wdataErr);
    else passed++;
    checks++;
    if ({doneCount - baseD, 1'b0} !== {1, job_error})
      $display("[TB] FAIL write_done_error: got done %0d err %b expected done 1 err 0", doneCount - baseD, job_error);
    else passed++;
  endtask

  task automatic test_read();
    int baseS;
    int baseR;
    int baseD;
    int baseQ;
    bit seen;
    logic [7:0] expByte;
    baseS = strobeCount;
    baseR = rdCount;
    baseQ = rreqCount;
    baseD = doneCount;
    runJob(23'h002000, 20'd8, 1'b1, 200, seen);
    checks++;
    if (seen !== 1'b1 || doneCount - baseD !== 1)
      $display("[TB] FAIL read_done: got seen %b count %0d expected 1/1", seen, doneCount - baseD);
    else passed++;
    checks++;
    if (strobeCount - baseS !== 1 || strRw[baseS] !== 1'b1 || strLen[baseS] !== 11'd8 || strAdr[baseS] !== 23'h002000)
      $display("[TB] FAIL read_strobe: got n %0d rw %b len %0d adr %h expected 1 1 8 002000",
               strobeCount - baseS, strRw[baseS], strLen[baseS], strAdr[baseS]);
    else passed++;
    checks++;
    if (rreqCount - baseQ !== 8 || lastRreqCycle - firstRreqCycle !== 7)
      $display("[TB] FAIL read_rreq_run: got %0d over %0d cycles expected 8 over 8",
               rreqCount - baseQ, lastRreqCycle - firstRreqCycle + 1);
    else passed++;
    checks++;
    if (!(busyFallCycle > strCycle[baseS] && firstRreqCycle >= busyFallCycle))
      $display("[TB] FAIL read_rreq_after_busy: got rreq at %0d busy fall %0d expected rreq after fall",
               firstRreqCycle, busyFallCycle);
    else passed++;
    checks++;
    if (rdCount - baseR !== 8 || lastRdCycle - firstRdCycle !== 7)
      $display("[TB] FAIL read_valid_run: got %0d over %0d cycles expected 8 over 8",
               rdCount - baseR, lastRdCycle - firstRdCycle + 1);
    else passed++;
    checks++;
    if (firstRdCycle - firstRreqCycle !== 2)
      $display("[TB] FAIL read_latency: got %0d expected 2", firstRdCycle - firstRreqCycle);
    else passed++;
    expByte = 8'h11;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (baseR + i >= 16 || rdLog[baseR+i] !== expByte)
        $display("[TB] FAIL read_data%0d: got %h expected %h", i, rdLog[(baseR+i) % 16], expByte);
      else passed++;
      expByte = expByte + 8'd1;
    end
  endtask

  task automatic test_odd_length();
    int baseS;
    int baseW;
    bit seen;
    baseS = strobeCount;
    baseW = wreqCount;
    wrMode = 1;
    runJob(23'h000040, 20'd7, 1'b0, 200, seen);
    wrMode = 0;
    checks++;
    if (seen !== 1'b1 || strobeCount - baseS !== 1 || strLen[baseS] !== 11'd6)
      $display("[TB] FAIL odd_len_strobe: got done %b n %0d len %0d expected 1 1 6",
               seen, strobeCount - baseS, strLen[baseS]);
    else passed++;
    checks++;
    if (wreqCount - baseW !== 6) $display("[TB] FAIL odd_len_bytes: got %0d expected 6", wreqCount - baseW);
    else passed++;
  endtask

  task automatic test_timeout();
    int baseS;
    int baseQ;
    int dt;
    bit seen;
    baseS = strobeCount;
    baseQ = rreqCount;
    busyEn = 1'b0;
    runJob(23'h000500, 20'd3000, 1'b1, 200, seen);
    checks++;
    if (seen !== 1'b1 || job_error !== 1'b1)
      $display("[TB] FAIL timeout_error: got done %b err %b expected 1 1", seen, job_error);
    else passed++;
    checks++;
    if (strobeCount - baseS !== 1 || rreqCount - baseQ !== 0)
      $display("[TB] FAIL timeout_no_more_bursts: got strobes %0d rreq %0d expected 1 0",
               strobeCount - baseS, rreqCount - baseQ);
    else passed++;
    dt = doneCycle - strCycle[baseS];
    checks++;
    if (!(dt >= 16 && dt <= 17)) $display("[TB] FAIL timeout_delay: got %0d expected 16..17", dt);
    else passed++;
    @(negedge clk_50);
    job_start = 1'b1;
    job_len   = 20'd0;
    @(negedge clk_50);
    job_start = 1'b0;
    #1;
    checks++;
    if (job_error !== 1'b0) $display("[TB] FAIL timeout_error_clear: got %b expected 0", job_error);
    else passed++;
    repeat (4) @(negedge clk_50);
    busyEn = 1'b1;
  endtask

  task automatic test_wrap();
    int baseS;
    int baseQ;
    bit seen;
    logic [22:0] expAdr [3];
    logic [10:0] expLen [3];
    expAdr[0] = 23'h7FFFFF; expAdr[1] = 23'h00027F; expAdr[2] = 23'h0004FF;
    expLen[0] = 11'd1280;   expLen[1] = 11'd1280;   expLen[2] = 11'd4;
    baseS = strobeCount;
    baseQ = rreqCount;
    runJob(23'h7FFFFF, 20'd2564, 1'b1, 8000, seen);
    checks++;
    if (seen !== 1'b1 || strobeCount - baseS !== 3)
      $display("[TB] FAIL wrap_strobes: got done %b n %0d expected 1 3", seen, strobeCount - baseS);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({strAdr[baseS+i], strLen[baseS+i]} !== {expAdr[i], expLen[i]})
        $display("[TB] FAIL wrap_burst%0d: got adr %h len %0d expected adr %h len %0d",
                 i, strAdr[baseS+i], strLen[baseS+i], expAdr[i], expLen[i]);
      else passed++;
    end
    checks++;
    if (rreqCount - baseQ !== 2564) $display("[TB] FAIL wrap_rreq_total: got %0d expected 2564", rreqCount - baseQ);
    else passed++;
  endtask

  task automatic test_reset_midload();
    int baseW;
    int baseD;
    int baseS;
    bit seen;
    baseW = wreqCount;
    baseD = doneCount;
    wrMode = 1;
    @(negedge clk_50);
    job_start = 1'b1;
    job_addr  = 23'h000300;
    job_len   = 20'd2000;
    job_rw    = 1'b0;
    @(negedge clk_50);
    job_start = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_50);
      #1;
      if (wreqCount - baseW >= 100) break;
    end
    checks++;
    if (wreqCount - baseW < 100) $display("[TB] FAIL midload_progress: got %0d expected >= 100", wreqCount - baseW);
    else passed++;
    @(negedge clk_50);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({job_busy, job_done, job_error, wr_ready, rd_data, rd_valid, ctl_adr, ctl_len,
         ctl_rw, ctl_strobe, ctl_wdata, ctl_wreq, ctl_rreq} !== 59'd0)
      $display("[TB] FAIL midload_reset_outputs: got busy=%b rdy=%b wreq=%b len=%0d expected all 0",
               job_busy, wr_ready, ctl_wreq, ctl_len);
    else passed++;
    repeat (2) @(negedge clk_50);
    resetn = 1'b1;
    repeat (3) @(negedge clk_50);
    #1;
    checks++;
    if (doneCount !== baseD || job_busy !== 1'b0)
      $display("[TB] FAIL midload_no_done: got done %0d busy %b expected 0 0", doneCount - baseD, job_busy);
    else passed++;
    baseW = wreqCount;
    baseS = strobeCount;
    runJob(23'h001000, 20'd4, 1'b0, 200, seen);
    wrMode = 0;
    checks++;
    if (seen !== 1'b1 || strobeCount - baseS !== 1 || strAdr[baseS] !== 23'h001000 ||
        strLen[baseS] !== 11'd4 || wreqCount - baseW !== 4)
      $display("[TB] FAIL midload_fresh_job: got done %b n %0d adr %h len %0d bytes %0d expected 1 1 001000 4 4",
               seen, strobeCount - baseS, strAdr[baseS], strLen[baseS], wreqCount - baseW);
    else passed++;
  endtask

  task automatic test_backpressure();
    int baseW;
    int baseS;
    bit seen;
    baseW = wreqCount;
    baseS = strobeCount;
    wrMode = 2;
    runJob(23'h000010, 20'd1280, 1'b0, 6000, seen);
    wrMode = 0;
    checks++;
    if (seen !== 1'b1 || strobeCount - baseS !== 1)
      $display("[TB] FAIL bp_strobe: got done %b n %0d expected 1 1", seen, strobeCount - baseS);
    else passed++;
    checks++;
    if (strWreq[baseS] - baseW !== 1280 || lastWreqCycle >= strCycle[baseS])
      $display("[TB] FAIL bp_bytes_before_strobe: got %0d last wreq %0d strobe %0d expected 1280 before strobe",
               strWreq[baseS] - baseW, lastWreqCycle, strCycle[baseS]);
    else passed++;
    checks++;
    if (wdataErr !== 0) $display("[TB] FAIL bp_data_order: got %0d bad bytes expected 0", wdataErr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_length();
    test_write_split();
    test_read();
    test_odd_length();
    test_timeout();
    test_wrap();
    test_reset_midload();
    test_backpressure();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
